// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between two requesters.
// Stores finish in the grant cycle; loads spend one RD_WAIT cycle so the read data returns to its issuer.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [1:0]            m0_width,
  input  logic                  m0_sext,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [1:0]            m1_width,
  input  logic                  m1_sext,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic [1:0]            ram_width,
  output logic                  ram_sext,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state, state_next;
  logic   last, last_next;
  logic   owner, owner_next;
  logic   grant0, grant1;

  // On contention the requester that was not granted most recently wins; reset blocks all grants.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (m0_req && m1_req) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = m0_req;
        grant1 = m1_req;
      end
    end
  end

  always_comb begin
    ram_addr  = m0_addr;
    ram_din   = m0_wdata;
    ram_width = m0_width;
    ram_sext  = m0_sext;
    if (grant1) begin
      ram_addr  = m1_addr;
      ram_din   = m1_wdata;
      ram_width = m1_width;
      ram_sext  = m1_sext;
    end
  end

  assign ram_we = (grant0 && m0_we) || (grant1 && m1_we);
  assign m0_gnt = grant0;
  assign m1_gnt = grant1;

  always_comb begin
    state_next = state;
    last_next  = last;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          last_next = grant1;
          if (!ram_we) begin
            state_next = RD_WAIT;
            owner_next = grant1;
          end
        end
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      last  <= last_next;
      owner <= owner_next;
    end
  end

  // A reset landing in RD_WAIT swallows the pending read response.
  assign m0_rvalid = !rst && state == RD_WAIT && !owner;
  assign m1_rvalid = !rst && state == RD_WAIT && owner;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a behavioural RAM and a reference arbiter/memory model.
// Grant-side behaviour is predicted each cycle; load data is queued at grant and checked when rvalid appears.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_width, m1_width;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we, ram_sext;
  logic [1:0]  ram_width;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  int         assertions = 0;
  int         failures = 0;
  logic [7:0] ram_mem [64] = '{default: 8'h00};
  logic [7:0] ref_mem [64] = '{default: 8'h00};
  int         model_last = 1;
  bit         model_busy = 0;
  int         model_owner = 0;
  bit         seen_gnt0 = 0;
  bit         seen_gnt1 = 0;

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_width(m0_width), .m0_sext(m0_sext), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_width(m1_width), .m1_sext(m1_sext), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_width(ram_width),
    .ram_sext(ram_sext), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Little-endian byte RAM with one-cycle read latency; narrow loads are extended inside the RAM.
  always @(posedge clk) begin
    int          b;
    logic [31:0] raw;
    b   = int'(ram_addr[5:0]);
    raw = {ram_mem[(b + 3) % 64], ram_mem[(b + 2) % 64], ram_mem[(b + 1) % 64], ram_mem[b]};
    case (ram_width)
      2'd0:    ram_dout <= {{24{ram_sext & raw[7]}}, raw[7:0]};
      2'd1:    ram_dout <= {{16{ram_sext & raw[15]}}, raw[15:0]};
      default: ram_dout <= raw;
    endcase
    if (ram_we) begin
      ram_mem[b] <= ram_din[7:0];
      if (ram_width != 2'd0) ram_mem[(b + 1) % 64] <= ram_din[15:8];
      if (ram_width[1]) begin
        ram_mem[(b + 2) % 64] <= ram_din[23:16];
        ram_mem[(b + 3) % 64] <= ram_din[31:24];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int accessBytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] w, input logic s);
    int    b = int'(a[5:0]);
    int    n = accessBytes(w);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[(b + i) % 64]);
    if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    int b = int'(a[5:0]);
    for (int i = 0; i < accessBytes(w); i++) ref_mem[(b + i) % 64] = 8'(d >> (8 * i));
  endtask

  // Reference arbiter: predicts grants, RAM-port fields and rvalid, then advances its own state.
  always @(negedge clk) begin
    int          win;
    bit          erv0, erv1, ewe, wwe, wsx;
    logic [31:0] wa, wd;
    logic [1:0]  ww;
    seen_gnt0 = m0_gnt;
    seen_gnt1 = m1_gnt;
    win  = -1;
    erv0 = 0;
    erv1 = 0;
    if (!rst) begin
      if (model_busy) begin
        erv0 = (model_owner == 0);
        erv1 = (model_owner == 1);
      end else if (m0_req && m1_req) win = (model_last == 0) ? 1 : 0;
      else if (m0_req) win = 0;
      else if (m1_req) win = 1;
    end
    wwe = (win == 1) ? m1_we : m0_we;
    wa  = (win == 1) ? m1_addr : m0_addr;
    wd  = (win == 1) ? m1_wdata : m0_wdata;
    ww  = (win == 1) ? m1_width : m0_width;
    wsx = (win == 1) ? m1_sext : m0_sext;
    ewe = (win >= 0) && wwe;
    checkOutput("m0_gnt", 32'(m0_gnt), 32'(win == 0));
    checkOutput("m1_gnt", 32'(m1_gnt), 32'(win == 1));
    checkOutput("ram_we", 32'(ram_we), 32'(ewe));
    checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
    checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
    if (win >= 0) begin
      checkOutput("ram_addr", ram_addr, wa);
      checkOutput("ram_width", 32'(ram_width), 32'(ww));
      checkOutput("ram_sext", 32'(ram_sext), 32'(wsx));
      if (wwe) checkOutput("ram_din", ram_din, wd);
    end
    if (rst) begin
      model_last = 1;
      model_busy = 0;
      sb.delete();
    end else if (model_busy) begin
      model_busy = 0;
    end else if (win >= 0) begin
      model_last = win;
      if (wwe) refStore(wa, wd, ww);
      else begin
        model_busy  = 1;
        model_owner = win;
        sb.push_back('{port: win, data: refLoad(wa, ww, wsx)});
      end
    end
  end

  // Read-response monitor: every rvalid must match the oldest outstanding load.
  always @(negedge clk) begin
    exp_t e;
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) checkOutput("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      else begin
        e = sb.pop_front();
        checkOutput("rvalid_port", 32'(m1_rvalid), 32'(e.port));
        checkOutput("rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input int p, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] width, input logic sext);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_width = width; m0_sext = sext;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_width = width; m1_sext = sext;
    end
  endtask

  task automatic randomTxn(input int p);
    logic [1:0]  w;
    logic [31:0] a;
    w = 2'($urandom_range(0, 3));
    if (w == 2'd0) a = 32'($urandom_range(0, 63));
    else if (w == 2'd1) a = 32'($urandom_range(0, 31) * 2);
    else a = 32'($urandom_range(0, 15) * 4);
    applyStimulus(p, 1'($urandom_range(0, 1)), a, $urandom, w, 1'($urandom_range(0, 1)));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (m0_req && seen_gnt0) m0_req = 1'b0;
    if (m1_req && seen_gnt1) m1_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m0_req || m1_req) && n < 50) begin
      stepCycle();
      n++;
    end
    if (n >= 50) begin
      checkOutput("drain_timeout", 32'({m1_req, m0_req}), 32'd0);
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    stepCycle();
    stepCycle();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_width = 0; m0_sext = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_width = 0; m1_sext = 0;
    stepCycle();
    stepCycle();

    // Both stores pending through reset: no grant while rst, then m0 first, m1 next.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    applyStimulus(1, 1'b1, 32'h14, 32'h12345678, 2'd2, 1'b0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    drain();

    // Sustained store contention alternates grants.
    for (int k = 0; k < 6; k++) begin
      if (!m0_req) applyStimulus(0, 1'b1, 32'h30, 32'hA0A0_0000 + 32'(k), 2'd2, 1'b0);
      if (!m1_req) applyStimulus(1, 1'b1, 32'h34, 32'hB0B0_0000 + 32'(k), 2'd2, 1'b0);
      stepCycle();
    end
    drain();

    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    drain();

    // With last = 0, an m1 load beats an m0 store and m0 waits out RD_WAIT.
    applyStimulus(0, 1'b1, 32'h18, 32'h55AA55AA, 2'd2, 1'b0);
    drain();
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
    applyStimulus(0, 1'b1, 32'h1C, 32'h01020304, 2'd2, 1'b0);
    drain();

    applyStimulus(0, 1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0);
    drain();
    applyStimulus(1, 1'b0, 32'h21, 32'h0, 2'd0, 1'b1);
    drain();

    // Reset during RD_WAIT discards the read; first contention afterwards goes to m0.
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 32'h24, 32'h11111111, 2'd2, 1'b0);
    applyStimulus(1, 1'b1, 32'h28, 32'h22222222, 2'd2, 1'b0);
    drain();

    // m1 requests only during m0's RD_WAIT and withdraws before the next IDLE cycle.
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    stepCycle();
    applyStimulus(1, 1'b1, 32'h3C, 32'hCAFEF00D, 2'd2, 1'b0);
    stepCycle();
    m1_req = 1'b0;
    drain();

    for (int c = 0; c < 3000; c++) begin
      stepCycle();
      if (!m0_req) begin
        if ($urandom_range(0, 2) != 0) randomTxn(0);
      end else if ($urandom_range(0, 19) == 0) m0_req = 1'b0;
      if (!m1_req) begin
        if ($urandom_range(0, 2) != 0) randomTxn(1);
      end else if ($urandom_range(0, 19) == 0) m1_req = 1'b0;
    end
    drain();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
